// File: rtl/vco_edge_decimator.sv
// vco_edge_decimator
//   Counts rising edges of the VCO phase output over a programmable window of
//   clk cycles and hands one count per window to the back-end as an ADC sample.
//   The block also enables the VCO (active-low enb) while converting.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   en           conversion enable (level)
//   decim        window length minus one, sampled only at window reload
//   vco_p        VCO phase output, asynchronous to clk
//   vco_enb      VCO enable, 0 = VCO runs
//   sample       edge count of the last completed window
//   sample_valid sample holds an unconsumed value
//   sample_ready consumer accepts the sample
//   overrun      sticky, a window result was dropped
//   busy         FSM is in SETTLE or RUN
module vco_edge_decimator #(
   parameter int CNT_W      = 16,
   parameter int DECIM_W    = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [DECIM_W-1:0] decim,
   input  logic               vco_p,
   output logic               vco_enb,
   output logic [CNT_W-1:0]   sample,
   output logic               sample_valid,
   input  logic               sample_ready,
   output logic               overrun,
   output logic               busy
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

   state_t             state, state_nxt;
   logic [2:0]         sync_pipe;   // [0]=s1, [1]=s2, [2]=s3
   logic               pulse;
   logic [SET_W-1:0]   set_cnt;
   logic [DECIM_W-1:0] win_cnt;
   logic [CNT_W-1:0]   acc;
   logic [CNT_W-1:0]   acc_sum;
   logic               settle_done;
   logic               win_end;

   // Three-flop synchronizer; edge detect uses the two settled stages only.
   always_ff @(posedge clk) begin
      if (!rst_n) sync_pipe <= '0;
      else        sync_pipe <= {sync_pipe[1:0], vco_p};
   end

   assign pulse = sync_pipe[1] & ~sync_pipe[2];

   // Saturating add of this cycle's pulse; also the window result at window end.
   assign acc_sum = (&acc) ? acc : acc + {{(CNT_W-1){1'b0}}, pulse};

   assign settle_done = (state == SETTLE) && (set_cnt == '0);
   // Window end is suppressed when en drops so an aborted window never reports.
   assign win_end     = (state == RUN) && en && (win_cnt == '0);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = SETTLE;
         SETTLE:  if (!en) state_nxt = IDLE;
                  else if (settle_done) state_nxt = RUN;
         RUN:     if (!en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      vco_enb = (state == IDLE);
      busy    = (state != IDLE);
   end

   // Settle counter, window counter and accumulator
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         set_cnt <= '0;
         win_cnt <= '0;
         acc     <= '0;
      end else begin
         case (state)
            IDLE: begin
               acc     <= '0;
               // Preloaded so SETTLE lasts exactly SETTLE_CYC cycles.
               set_cnt <= SET_W'(SETTLE_CYC - 1);
            end
            SETTLE: begin
               if (set_cnt != '0) set_cnt <= set_cnt - SET_W'(1);
               if (settle_done) begin
                  win_cnt <= decim;
                  acc     <= '0;
               end
            end
            RUN: begin
               // Reload on the closing cycle itself: no gap between windows.
               if (win_cnt == '0) begin
                  acc     <= '0;
                  win_cnt <= decim;
               end else begin
                  acc     <= acc_sum;
                  win_cnt <= win_cnt - DECIM_W'(1);
               end
            end
            default: begin
               acc     <= '0;
               set_cnt <= '0;
            end
         endcase
      end
   end

   // Output register and handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample       <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if ((state == IDLE) && en) overrun <= 1'b0;
         if (win_end) begin
            if (!sample_valid || sample_ready) begin
               sample       <= acc_sum;
               sample_valid <= 1'b1;
            end else begin
               // Unconsumed sample is kept stable; the new result is lost.
               overrun <= 1'b1;
            end
         end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vco_edge_decimator.sv
// Directed testbench for vco_edge_decimator: reset, nominal windows,
// backpressure/overrun, window-length change, abort/re-enable, mid-run reset
// and accumulator saturation (second instance with a 4-bit count).
module tb_vco_edge_decimator;

   logic        clk = 1'b0;
   logic        rst_n, en, vco_p, sample_ready, sample_ready2;
   logic [15:0] decim, decim2;
   logic        vco_enb, sample_valid, overrun, busy;
   logic [15:0] sample;
   logic        vco_enb2, sample_valid2, overrun2, busy2;
   logic [3:0]  sample2;
   int          total = 0;
   int          bad = 0;
   int          n;
   int          sum;

   always #5 clk = ~clk;

   vco_edge_decimator #(.CNT_W(16), .DECIM_W(16), .SETTLE_CYC(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .decim(decim), .vco_p(vco_p),
      .vco_enb(vco_enb), .sample(sample), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .overrun(overrun), .busy(busy)
   );

   vco_edge_decimator #(.CNT_W(4), .DECIM_W(16), .SETTLE_CYC(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .decim(decim2), .vco_p(vco_p),
      .vco_enb(vco_enb2), .sample(sample2), .sample_valid(sample_valid2),
      .sample_ready(sample_ready2), .overrun(overrun2), .busy(busy2)
   );

   // VCO model: toggles every clk cycle, i.e. one rising edge per 2 cycles.
   initial begin
      vco_p = 1'b0;
      forever @(negedge clk) vco_p = ~vco_p;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   task automatic step(input int cyc);
      repeat (cyc) @(negedge clk);
   endtask

   // Counts cycles until sample_valid is seen; returns max on timeout.
   task automatic wait_valid(input bit sat, input int max, output int cyc);
      cyc = 0;
      while (((sat ? sample_valid2 : sample_valid) !== 1'b1) && (cyc < max)) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; decim = 16'd7; decim2 = 16'd63;
      sample_ready = 1'b1; sample_ready2 = 1'b1;

      // Reset with en high and vco_p toggling
      step(3);
      chk("rst_vco_enb", vco_enb, 1);
      chk("rst_valid", sample_valid, 0);
      chk("rst_sample", sample, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sat_sample", sample2, 0);

      // Nominal: decim=7, ready=1
      rst_n = 1'b1;
      step(1);
      chk("en_busy", busy, 1);
      chk("en_vco_enb", vco_enb, 0);
      chk("en_valid", sample_valid, 0);
      wait_valid(0, 40, n);
      chk("nom_first_latency", n, 12);
      chk("nom_sample0", sample, 4);
      sum = sample;
      step(1);
      chk("nom_valid_pulse", sample_valid, 0);
      wait_valid(0, 40, n);
      chk("nom_period1", n, 7);
      chk("nom_sample1", sample, 4);
      sum += sample;
      step(1);
      wait_valid(0, 40, n);
      chk("nom_period2", n, 7);
      sum += sample;
      chk("nom_sum", sum, 12);

      // Backpressure; decim changed mid-window (current window stays 8)
      step(1);
      chk("bp_valid_idle", sample_valid, 0);
      sample_ready = 1'b0; decim = 16'd15;
      wait_valid(0, 40, n);
      chk("bp_period", n, 7);
      chk("bp_sample_a", sample, 4);
      chk("bp_overrun_pre", overrun, 0);
      step(16);
      chk("bp_valid_held", sample_valid, 1);
      chk("bp_sample_kept", sample, 4);
      chk("bp_overrun_set", overrun, 1);
      sample_ready = 1'b1; decim = 16'd7;
      step(1);
      chk("bp_consumed", sample_valid, 0);
      wait_valid(0, 40, n);
      chk("wc_long_period", n, 15);
      chk("wc_long_sample", sample, 8);
      chk("bp_overrun_sticky", overrun, 1);
      step(1);
      wait_valid(0, 40, n);
      chk("wc_back_period", n, 7);
      chk("wc_back_sample", sample, 4);

      // Abort at cycle 3 of a window with a pending sample and overrun set
      sample_ready = 1'b0;
      step(2);
      en = 1'b0;
      step(1);
      chk("ab_vco_enb", vco_enb, 1);
      chk("ab_busy", busy, 0);
      chk("ab_valid_pending", sample_valid, 1);
      chk("ab_overrun_kept", overrun, 1);
      step(10);
      chk("ab_no_new_valid", sample_valid, 1);
      chk("ab_sample_kept", sample, 4);
      sample_ready = 1'b1;
      step(1);
      chk("ab_pending_taken", sample_valid, 0);
      chk("ab_overrun_idle", overrun, 1);

      // Re-enable: overrun clears, 4 settle cycles then an 8-cycle window
      en = 1'b1;
      step(1);
      chk("re_overrun_clr", overrun, 0);
      chk("re_busy", busy, 1);
      wait_valid(0, 40, n);
      chk("re_latency", n, 12);
      chk("re_sample", sample, 4);

      // Reset in the middle of a run
      rst_n = 1'b0;
      step(1);
      chk("mr_valid", sample_valid, 0);
      chk("mr_sample", sample, 0);
      chk("mr_vco_enb", vco_enb, 1);
      chk("mr_busy", busy, 0);

      // Saturation: 4-bit count, 64-cycle window, 32 edges -> 15
      rst_n = 1'b1;
      step(1);
      wait_valid(1, 120, n);
      chk("sat_latency", n, 68);
      chk("sat_sample", sample2, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
